// File: rtl/adder_pkg.sv
// Shared constants for the nibble-serial adder: FSM encodings, nibble width, counter sizing.
// Latency: none (package only).
// Backpressure: n/a.
package adder_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Width of a counter that indexes n nibbles; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ripple_carry_adder_4_bit.sv
// 4-bit ripple-carry adder, the per-nibble datapath of the serial adder.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b - 4-bit addends; c_in - carry in; sum - 4-bit result; c_out - carry out of bit 3.
module ripple_carry_adder_4_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [4:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign c_out = carry[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that reuses one 4-bit adder, one nibble per clock, LSB nibble first.
// Latency: out_valid rises NIBBLES edges after the accept edge; initiation interval NIBBLES+2.
// Backpressure: result held in DONE until out_ready; no new operands taken until back in IDLE.
// Ports: clk/rst (async active-high); in_valid/in_ready with a, b, c_in;
//        out_valid/out_ready with sum, c_out (carry out of MSB), overflow (signed overflow).
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                        c_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                        c_out,
  output logic                        overflow
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int CW = cnt_w(NIBBLES);
  localparam logic [CW-1:0] LAST_IDX = CW'(NIBBLES - 1);

  logic [1:0]          state;
  logic [W-1:0]        a_sh;
  logic [W-1:0]        b_sh;
  logic [W-1:0]        sum_sh;
  logic                carry_r;
  logic [CW-1:0]       idx;
  logic                a_msb;
  logic                b_msb;

  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_co;
  logic [W-1:0]        sum_sh_nxt;

  ripple_carry_adder_4_bit u_nib_add (
    .a     (a_sh[NIBBLE_W-1:0]),
    .b     (b_sh[NIBBLE_W-1:0]),
    .c_in  (carry_r),
    .sum   (nib_sum),
    .c_out (nib_co)
  );

  // New nibble enters at the top so that after NIBBLES shifts the first
  // (least significant) nibble has walked down to bit 0.
  assign sum_sh_nxt = W'({nib_sum, sum_sh} >> NIBBLE_W);

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      carry_r  <= 1'b0;
      idx      <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_r <= c_in;
            idx     <= '0;
            a_msb   <= a[W-1];
            b_msb   <= b[W-1];
            state   <= ADD;
          end
        end
        ADD: begin
          a_sh    <= a_sh >> NIBBLE_W;
          b_sh    <= b_sh >> NIBBLE_W;
          sum_sh  <= sum_sh_nxt;
          carry_r <= nib_co;
          idx     <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            sum      <= sum_sh_nxt;
            c_out    <= nib_co;
            // Same-sign operands producing an opposite-sign result.
            overflow <= (a_msb == b_msb) && (sum_sh_nxt[W-1] != a_msb);
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;

  nibble_serial_adder #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Hand-computed expectations for directed operations.
  int           lit_seq = 0;
  logic [W-1:0] lit_sum;
  logic         lit_cout;
  logic         lit_ovf;
  int           to_cnt = 0;

  // Reference: plain integer arithmetic, unsigned for sum/carry, signed range test for overflow.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    longint       u;
    longint       s;
    logic [W-1:0] r;
    logic         co;
    logic         ov;
    u  = longint'(x) + longint'(y) + longint'(ci);
    r  = u[W-1:0];
    co = u[W];
    s  = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
    ov = (s > ((longint'(1) << (W - 1)) - 1)) || (s < -(longint'(1) << (W - 1)));
    return {ov, co, r};
  endfunction

  // Transaction-level model: -1 = waiting for operands, k>0 = k edges until result, 0 = result held.
  int           m_wait = -1;
  logic [W+1:0] m_pend;
  logic [W-1:0] m_sum  = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf  = 1'b0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_wait = -1;
        m_sum  = '0;
        m_cout = 1'b0;
        m_ovf  = 1'b0;
      end else if (m_wait < 0) begin
        if (in_valid) begin
          m_pend = ref_add(a, b, c_in);
          m_wait = NIB;
        end
      end else if (m_wait > 0) begin
        m_wait = m_wait - 1;
        if (m_wait == 0) begin
          m_sum  = m_pend[W-1:0];
          m_cout = m_pend[W];
          m_ovf  = m_pend[W+1];
        end
      end else if (out_ready) begin
        m_wait = -1;
      end
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process, on the falling edge.
  initial begin
    int lit_seen;
    int to_seen;
    lit_seen = 0;
    to_seen  = 0;
    forever begin
      @(negedge clk);
      chk("in_ready",  W'(in_ready),  W'(!rst && (m_wait < 0)));
      chk("out_valid", W'(out_valid), W'(m_wait == 0));
      chk("sum",       sum,           m_sum);
      chk("c_out",     W'(c_out),     W'(m_cout));
      chk("overflow",  W'(overflow),  W'(m_ovf));
      if (out_valid && (lit_seq != lit_seen)) begin
        chk("lit_sum",  sum,           lit_sum);
        chk("lit_cout", W'(c_out),     W'(lit_cout));
        chk("lit_ovf",  W'(overflow),  W'(lit_ovf));
        lit_seen = lit_seq;
      end
      if (to_cnt != to_seen) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL timeout: got %0d expired waits expected 0 at %0t", to_cnt - to_seen, $time);
        to_seen = to_cnt;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_lit(input logic [W-1:0] s, input logic co, input logic ov);
    lit_sum  = s;
    lit_cout = co;
    lit_ovf  = ov;
    lit_seq  = lit_seq + 1;
  endtask

  // Holds in_valid until the operands are taken; returns just after the accept edge.
  task automatic wait_accept();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) to_cnt = to_cnt + 1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a    = W'($urandom);
    b    = W'($urandom);
    c_in = 1'($urandom_range(0, 1));
  endtask

  // Returns on the falling edge where out_valid is first seen.
  task automatic wait_result();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) to_cnt = to_cnt + 1;
  endtask

  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    a        = x;
    b        = y;
    c_in     = ci;
    in_valid = 1'b1;
    wait_accept();
  endtask

  task automatic directed(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                          input logic [W-1:0] es, input logic ec, input logic eo);
    set_lit(es, ec, eo);
    start_op(x, y, ci);
    wait_result();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '1;
      1:       v = '0;
      2:       v = {1'b1, {(W-1){1'b0}}};
      3:       v = {1'b0, {(W-1){1'b1}}};
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;
    out_ready = 1'b1;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    directed(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    directed(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Backpressure with competing operands offered while the result is held.
    out_ready = 1'b0;
    set_lit(16'h8000, 1'b0, 1'b1);
    start_op(16'h7FFF, 16'h0001, 1'b0);
    wait_result();
    a        = 16'h0F0F;
    b        = 16'h0101;
    c_in     = 1'b0;
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    set_lit(16'h1010, 1'b0, 1'b0);
    wait_accept();
    wait_result();
    @(posedge clk);
    #1;

    // Reset after the second ADD edge; no result may appear.
    start_op(16'hAAAA, 16'h5555, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    directed(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Randomized traffic with random producer gaps and consumer stalls.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = pick_operand();
      b         = pick_operand();
      c_in      = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-nibble operand sequencer that sits directly upstream of ripple_carry_adder_4_bit and consumes its outputs. It accepts two N-nibble operands over a valid/ready handshake and feeds them to the 4-bit adder one nibble per clock, LSB nibble first. The nibble carry is registered between cycles, and the result nibbles are collected into a full-width sum. The result is presented on a valid/ready output handshake. This lets the existing 4-bit adder serve wide additions at one nibble per cycle.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand; operand/sum width W = 4*NIBBLES; legal range 1..16

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands a, b, c_in are valid
in_ready  output  1  block can accept operands (IDLE only)
a  input  W  operand A, unsigned or two's complement
b  input  W  operand B
c_in  input  1  carry into nibble 0
out_valid  output  1  sum, c_out, overflow are valid
out_ready  input  1  consumer accepts result
sum  output  W  a + b + c_in, modulo 2^W
c_out  output  1  carry out of the MSB nibble
overflow  output  1  signed overflow of the W-bit add

Behaviour:
- Reset (async, rst=1): state=IDLE; sum=0, c_out=0, overflow=0, out_valid=0; internal shift registers, carry register and nibble counter cleared.
- in_ready is 0 while rst=1.
- In-flight operations are discarded on reset; no partial result is ever presented.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid&&in_ready: latch a→a_sh, b→b_sh, c_in→carry_r; set idx=0; latch a[W-1], b[W-1] for the overflow check; go to ADD.
- ADD:
  - in_ready=0. The adder sees a_sh[3:0], b_sh[3:0] and carry_r.
  - Each edge: a_sh and b_sh shift right by 4; the adder's 4-bit out is shifted into sum_sh from the top; carry_r takes the adder's c_out; idx increments.
  - When idx==NIBBLES-1 on that edge, go to DONE and load the outputs:
    - sum = final sum_sh
    - c_out = final carry
    - overflow = (a_msb==b_msb) && (sum[W-1]!=a_msb)
- DONE:
  - out_valid=1; sum, c_out and overflow are held stable.
  - in_valid is ignored.
  - On an edge with out_valid&&out_ready: return to IDLE, clear out_valid, keep the last sum/c_out/overflow values.
- Latency: out_valid rises exactly NIBBLES edges after the accept edge. Minimum initiation interval is NIBBLES+2 cycles (accept, NIBBLES ADD edges, handshake).
- NIBBLES=1: a single ADD edge, then DONE.
- Width rules:
  - Sum is modulo 2^W; c_out is bit W of the full sum.
  - overflow is computed for two's-complement interpretation regardless of use.
- Simultaneous events: in DONE, out_ready and a new in_valid in the same cycle accepts nothing new. The new operand is accepted no earlier than the first IDLE cycle.
- Operands may change freely after the accept edge; only the latched copies are used.
- The datapath adder must add bit i of A to bit i of B for all i. The bench checks results numerically, so any operand bit misrouting in the adder fails.

Decomposition:
- Shared package/include adder_pkg:
  - FSM state encodings (IDLE=2'd0, ADD=2'd1, DONE=2'd2)
  - NIBBLE_W=4 constant
  - counter width function (clog2 of NIBBLES)
- One sub-module: the existing ripple_carry_adder_4_bit, instantiated once as the combinational nibble datapath.
- Sequencing, shift registers and handshake live in nibble_serial_adder itself.

Test Plan:
- Reset, NIBBLES=4: rst=1 for 3 cycles → in_ready=0, out_valid=0, sum=16'h0000, c_out=0, overflow=0. After release, in_ready=1 on the next cycle.
- Basic add: a=16'h1234, b=16'h4321, c_in=0 → out_valid high 4 edges after accept; sum=16'h5555, c_out=0, overflow=0.
- Full carry ripple: a=16'hFFFF, b=16'h0000, c_in=1 → sum=16'h0000, c_out=1, overflow=0. Carry crosses all four nibble boundaries.
- Signed overflow: a=16'h7FFF, b=16'h0001, c_in=0 → sum=16'h8000, c_out=0, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, and drive in_valid=1 with a=16'h0F0F, b=16'h0101 meanwhile.
  - Expect out_valid to remain 1 with the previous result stable, and in_ready=0.
  - Drive out_ready=1 → IDLE, then the new operand is accepted; sum=16'h1010.
- Reset mid-operation: assert rst after the 2nd ADD edge of 16'hAAAA+16'h5555.
  - Expect all outputs 0 immediately and no result delivered.
  - Next op 16'h0001+16'h0001, c_in=0 → sum=16'h0002, c_out=0.
